uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: accepts a parallel byte from the system side with a single-cycle valid strobe and shifts it onto the serial line as one frame. The frame is a start bit, the data bits LSB first, an optional even or odd parity bit, and one stop bit. It is the transmit half of the UART, mirroring the receive path, and runs on the already-divided TX bit clock (one bit per CLK cycle). Framing, parity generation and busy signalling are all contained in this block.

## Interface
- DATA_WIDTH, 8, number of data bits per frame; bit counter width is clog2(DATA_WIDTH)
- CLK  input  1  TX bit clock; one serial bit per rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  parallel data; sampled only on accept
- Data_Valid  input  1  request to send P_DATA; sampled on rising CLK
- PAR_EN  input  1  1 = parity bit inserted; sampled on accept
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on accept
- TX_OUT  output  1  serial line, registered, idles high
- Busy  output  1  registered, high while a frame is on the line

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - TX_OUT=1, Busy=0.
  - Data_Valid=1 at a rising edge accepts the request: latch P_DATA, PAR_EN and PAR_TYP, clear the bit counter, go to START.
- START: TX_OUT=0, Busy=1; next state is DATA.
- DATA
  - TX_OUT = latched data[bit_cnt], starting at bit 0 (LSB).
  - bit_cnt increments every cycle; after bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY
  - TX_OUT = XOR of latched data when PAR_TYP=0 (even).
  - TX_OUT = XNOR of latched data when PAR_TYP=1 (odd).
  - Next state is STOP.
- STOP: TX_OUT=1, Busy=1; next state is always IDLE.
- Data_Valid is ignored in every state except IDLE; no queuing, the request is dropped.
- Changes to P_DATA, PAR_EN or PAR_TYP after accept have no effect on the frame in flight.
- Parity is computed from the latched register, never from the live P_DATA.
- Back-to-back traffic with Data_Valid held high: each frame is followed by exactly one IDLE cycle (TX_OUT=1, Busy=0), then the next START.
- Invalid or unreachable state encodings return to IDLE.

## Timing
- Reset (RST=0, asynchronous, effective immediately):
  - TX_OUT=1, Busy=0, state=IDLE.
  - Data/config registers and bit counter = 0.
- Reset mid-frame aborts the frame: TX_OUT goes high with no glitch low and the frame is truncated. The first accept after RST deasserts starts a clean frame.
- Accept at edge E0 (IDLE, Data_Valid=1) gives this sequence after each edge:
  - after E0: TX_OUT=0 (start), Busy=1
  - after E1..E8: data bits 0..7
  - after E9: parity if enabled, else stop
  - after E10: stop (parity case) or IDLE
  - after E11: IDLE (parity case)
- Frame length on the line: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Minimum accept-to-accept spacing: DATA_WIDTH+3 cycles without parity, DATA_WIDTH+4 with parity.
- Busy rises one cycle after the accept edge and falls with the same edge that returns TX_OUT to idle after the stop bit.
- No combinational path from any input to TX_OUT or Busy.

## Test plan
- Reset: hold RST=0 -> TX_OUT=1, Busy=0; Data_Valid pulses during reset are ignored.
- 0xA5 with PAR_EN=1, PAR_TYP=0 -> TX_OUT after E0..E10 is 0,1,0,1,0,0,1,0,1,0,1 and Busy is high for those 11 cycles. Repeat with PAR_TYP=1 -> parity bit becomes 1.
- 0x00 with PAR_EN=0 -> 0, eight 0s, then 1 (10 cycles), Busy low on the 11th cycle. 0xFF odd parity -> parity bit 1.
- Data_Valid pulsed with 0x3C mid-frame while sending 0x81, with P_DATA also changing -> the 0x81 frame completes unchanged and 0x3C is never transmitted.
- Data_Valid held high with P_DATA=0x55, PAR_EN=0 -> frames repeat every 11 cycles with exactly one idle-high cycle between them.
- RST asserted during data bit 3 -> TX_OUT=1 and Busy=0 immediately. After release, a new request for 0x0F produces a correct full frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter framing one byte as start, LSB-first data, optional parity, stop.
// Runs on the divided bit clock; TX_OUT and Busy are registered from the next-state decode.
module uart_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);
   localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t                state, next_state;
   logic [DATA_WIDTH-1:0] data_r;
   logic                  par_en_r, par_typ_r;
   logic [CW-1:0]         bit_cnt, cnt_nxt;
   logic                  tx_nxt, busy_nxt;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         data_r    <= '0;
         par_en_r  <= 1'b0;
         par_typ_r <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         state   <= next_state;
         bit_cnt <= cnt_nxt;
         if (state == IDLE && Data_Valid) begin
            data_r    <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
         end
      end
   end
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE:    next_state = Data_Valid ? START : IDLE;
         START:   next_state = DATA;
         DATA:    next_state = (bit_cnt == CW'(DATA_WIDTH - 1)) ? (par_en_r ? PARITY : STOP) : DATA;
         PARITY:  next_state = STOP;
         default: next_state = IDLE;
      endcase
      cnt_nxt = (state == DATA) ? bit_cnt + CW'(1) : '0;
   end
   // Outputs are decoded from the upcoming state so the registered line changes on the same edge.
   always_comb begin
      tx_nxt   = (next_state == START)  ? 1'b0 :
                 (next_state == DATA)   ? data_r[cnt_nxt] :
                 (next_state == PARITY) ? (^data_r) ^ par_typ_r : 1'b1;
      busy_nxt = next_state != IDLE;
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         TX_OUT <= 1'b1;
         Busy   <= 1'b0;
      end else begin
         TX_OUT <= tx_nxt;
         Busy   <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks for uart_tx with hand-written expected bit sequences.
module tb_uart_tx;
   logic       CLK = 1'b0, RST = 1'b0, Data_Valid = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       TX_OUT, Busy;
   int         tests = 0, fails = 0;
   logic [10:0] seq55 = 11'b0101010101;
   always #5 CLK = ~CLK;
   uart_tx #(.DATA_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
   );
   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask
   // seq holds TX_OUT after E0..E(n-1), written E0 first (MSB side).
   task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                        input logic [10:0] seq, input int n, input int inj);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         Data_Valid = (i == inj);
         if (i == inj) begin
            P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1;
         end
         chk($sformatf("%s tx E%0d", tag, i), TX_OUT, seq[n-1-i]);
         chk($sformatf("%s busy E%0d", tag, i), Busy, 1'b1);
      end
      @(negedge CLK);
      Data_Valid = 1'b0;
      chk($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
      chk($sformatf("%s idle busy", tag), Busy, 1'b0);
   endtask
   initial begin
      Data_Valid = 1'b1; P_DATA = 8'hFF;
      repeat (3) @(negedge CLK);
      chk("reset tx", TX_OUT, 1'b1);
      chk("reset busy", Busy, 1'b0);
      Data_Valid = 1'b0; RST = 1'b1;
      @(negedge CLK);
      chk("post reset tx", TX_OUT, 1'b1);
      chk("post reset busy", Busy, 1'b0);
      frame("a5_even", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, -1);
      frame("a5_odd",  8'hA5, 1'b1, 1'b1, 11'b01010010111, 11, -1);
      frame("00_nopar", 8'h00, 1'b0, 1'b0, 11'b0000000001, 10, -1);
      frame("ff_odd",  8'hFF, 1'b1, 1'b1, 11'b01111111111, 11, -1);
      frame("81_ignore", 8'h81, 1'b0, 1'b0, 11'b0100000011, 10, 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk($sformatf("no 3c tx %0d", i), TX_OUT, 1'b1);
         chk($sformatf("no 3c busy %0d", i), Busy, 1'b0);
      end
      @(negedge CLK);
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      for (int k = 0; k < 33; k++) begin
         @(negedge CLK);
         if (k == 32) Data_Valid = 1'b0;
         chk($sformatf("b2b tx %0d", k), TX_OUT, (k % 11 < 10) ? seq55[9 - (k % 11)] : 1'b1);
         chk($sformatf("b2b busy %0d", k), Busy, (k % 11) < 10);
      end
      @(negedge CLK);
      chk("b2b end tx", TX_OUT, 1'b1);
      chk("b2b end busy", Busy, 1'b0);
      P_DATA = 8'hA5; PAR_EN = 1'b0; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (4) @(negedge CLK);
      chk("bit3 before reset tx", TX_OUT, 1'b0);
      RST = 1'b0;
      #1;
      chk("midframe reset tx", TX_OUT, 1'b1);
      chk("midframe reset busy", Busy, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      frame("0f_after_reset", 8'h0F, 1'b0, 1'b0, 11'b0111100001, 10, -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
